round_engine: RTL
=================

# round_engine

Parametrised AES-style round unit for the chaos-based image encryptor. It holds its own 256-entry S-box table, loaded byte-serially from the chaotic S-box generator stream, and substitutes LANES bytes per cycle. It then applies ShiftRows, MixColumns (skipped on final rounds) and AddRoundKey. Both the input and output sides use valid/ready handshakes with backpressure, so the key-schedule/round controller can sit upstream and the ciphertext buffer downstream.

## Interface
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; SUB phase lasts 16/LANES cycles
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- sbox_in  in  8  next S-box table entry from generator stream
- sbox_in_valid  in  1  sbox_in is valid this cycle
- sbox_load_start  in  1  one-cycle pulse: restart table load at entry 0
- sbox_ready  out  1  all 256 entries loaded since last load start
- s_valid  in  1  input block valid
- s_ready  out  1  engine accepts a block this cycle
- s_state  in  128  input state; byte i = s_state[127-8i -: 8], column-major (FIPS-197)
- s_key  in  128  round key, same byte order
- s_last  in  1  final round: bypass MixColumns
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_state  out  128  round result
- busy  out  1  FSM not in IDLE

## Operation
- Reset: sbox_ready=0, load pointer=0, s_ready=0, m_valid=0, m_state=0, busy=0, FSM=IDLE. Table contents are not reset.
- Table load:
  - Each sbox_in_valid with sbox_ready=0 writes table[ptr]=sbox_in and increments ptr.
  - The write at ptr=255 sets sbox_ready=1. With sbox_ready=1, sbox_in_valid is ignored.
- sbox_load_start is accepted in any state except SUB. It clears sbox_ready and sets ptr=0.
  - In SUB it is ignored (dropped, not deferred).
  - If sbox_in_valid arrives in the same cycle, load_start wins and the byte is discarded.
- FSM states IDLE, SUB, MIX, OUT:
  - IDLE: s_ready = sbox_ready. On s_valid&&s_ready, latch state, key and last; clear byte index k=0; go to SUB.
  - SUB: each cycle, bytes k..k+LANES-1 are replaced by table[byte]; k += LANES. After the cycle with k=16-LANES, go to MIX.
  - MIX: the following is computed combinationally and registered into m_state, then go to OUT:
    - ShiftRows: row r rotated left by r.
    - MixColumns: GF(2^8), polynomial 0x11B, matrix {02 03 01 01} circulant; skipped if last=1.
    - AddRoundKey: XOR with the latched key.
  - OUT: m_valid=1, m_state held stable. On m_ready, go to IDLE with m_valid=0 next cycle.
- s_ready is low in SUB, MIX and OUT. No new block is accepted until the result is taken.
- Table writes during OUT or IDLE do not affect the held m_state.

## Timing
- Acceptance edge = cycle 0. m_valid rises after edge 16/LANES+1:
  - LANES=1: 17 cycles.
  - LANES=4: 5 cycles.
  - LANES=16: 2 cycles.
- Minimum block period with m_ready tied high: 16/LANES+3 cycles (accept, SUB×16/LANES, MIX, OUT).
- m_valid and m_state are registered outputs.
- s_ready, sbox_ready and busy are registered or derived from FSM state only, never from s_valid.
- sbox_ready rises the cycle after the 256th accepted byte.
- Reset asserted mid-operation: outputs go to reset values immediately, and any in-flight block is lost.
  - The table must be reloaded before s_ready can rise again.
- m_ready low in OUT: the FSM holds indefinitely, with m_state and m_valid unchanged.

## Test plan
- Identity table (entry i = i), LANES=4, last=1, key=0, input 00112233445566778899aabbccddeeff:
  - Expected m_state = 0055aaff4499ee3388dd2277cc1166bb.
  - m_valid rises 5 cycles after acceptance.
- FIPS-197 S-box, last=0, state 193de3bea0f4e22b9ac68d2ae9f84808, key a0fafe1788542cb123a339392a6c7605:
  - Expected m_state = a49c7ff2689f352b6b5bea43026a5049.
  - Repeat for LANES=1,2,8,16, checking latency 16/LANES+1 in each case.
- FIPS-197 S-box, last=1, state eb40f21e592e38848ba113e71bc342d2, key d014f9a8c9ee2589e13f0cc8b6630ca6:
  - Expected m_state = 3925841d02dc09fbdc118597196a0b32.
- Backpressure: hold m_ready=0 for 10 cycles in OUT.
  - m_state stays stable and s_ready stays 0.
  - With s_valid held high, the second block is accepted only after the m_ready handshake.
- Reload:
  - load_start pulsed during SUB: ignored.
  - load_start pulsed in IDLE: sbox_ready drops; s_ready stays 0 until 256 bytes arrive.
  - A byte coincident with load_start is dropped, so the table is shifted correctly.
- Reset mid-SUB: all outputs go to 0, sbox_ready=0, and no m_valid appears until the table is reloaded and a new block is sent.

Source files
------------

// File: rtl/round_engine.sv
// round_engine: S-box table loaded byte-serially from the generator stream, followed by one
// AES-style round (SubBytes over LANES bytes per cycle, ShiftRows, optional MixColumns, AddRoundKey).
module round_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   sbox_in,
    input  logic         sbox_in_valid,
    input  logic         sbox_load_start,
    output logic         sbox_ready,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_state,
    input  logic [127:0] s_key,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_state,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, MIX = 2'd2, OUT = 2'd3} state_e;

    localparam logic [4:0] K_STEP = 5'(LANES);
    localparam logic [4:0] K_LAST = 5'(16 - LANES);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    state_e         state_q, state_d;
    logic [127:0]   blk_q, blk_d;
    logic [127:0]   key_q, key_d;
    logic           last_q, last_d;
    logic [4:0]     k_q, k_d;
    logic [7:0]     ptr_q, ptr_d;
    logic           rdy_q, rdy_d;
    logic [127:0]   mst_q, mst_d;
    logic           mval_q, mval_d;
    logic [7:0]     sbox_mem [256];
    logic           load_acc_s;
    logic           tbl_we_s;
    logic [127:0]   shifted_s;

    // A restart is dropped while SubBytes is reading the table; a coincident data byte loses to it.
    always_comb begin
        load_acc_s = sbox_load_start && (state_q != SUB);
        tbl_we_s   = sbox_in_valid && !rdy_q && !load_acc_s;
        ptr_d      = ptr_q;
        rdy_d      = rdy_q;
        if (load_acc_s) begin
            ptr_d = 8'd0;
            rdy_d = 1'b0;
        end else if (tbl_we_s) begin
            ptr_d = ptr_q + 8'd1;
            rdy_d = (ptr_q == 8'hff);
        end else begin
            ptr_d = ptr_q;
            rdy_d = rdy_q;
        end
    end

    // Table storage: contents survive reset, only the load pointer is cleared.
    always_ff @(posedge clk) begin
        if (tbl_we_s) begin
            sbox_mem[ptr_q] <= sbox_in;
        end
    end

    // Round FSM next-state and datapath.
    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        key_d     = key_q;
        last_d    = last_q;
        k_d       = k_q;
        mst_d     = mst_q;
        mval_d    = mval_q;
        shifted_s = shift_rows(blk_q);
        case (state_q)
            IDLE: begin
                if (s_valid && rdy_q) begin
                    blk_d   = s_state;
                    key_d   = s_key;
                    last_d  = s_last;
                    k_d     = 5'd0;
                    state_d = SUB;
                end else begin
                    state_d = IDLE;
                end
            end
            SUB: begin
                for (int j = 0; j < LANES; j++) begin
                    blk_d[127 - 8*(int'(k_q) + j) -: 8] = sbox_mem[blk_q[127 - 8*(int'(k_q) + j) -: 8]];
                end
                if (k_q == K_LAST) begin
                    state_d = MIX;
                end else begin
                    k_d = k_q + K_STEP;
                end
            end
            MIX: begin
                mst_d   = (last_q ? shifted_s : mix_columns(shifted_s)) ^ key_q;
                mval_d  = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    mval_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                mval_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            blk_q   <= 128'd0;
            key_q   <= 128'd0;
            last_q  <= 1'b0;
            k_q     <= 5'd0;
            ptr_q   <= 8'd0;
            rdy_q   <= 1'b0;
            mst_q   <= 128'd0;
            mval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            last_q  <= last_d;
            k_q     <= k_d;
            ptr_q   <= ptr_d;
            rdy_q   <= rdy_d;
            mst_q   <= mst_d;
            mval_q  <= mval_d;
        end
    end

    assign sbox_ready = rdy_q;
    assign s_ready    = (state_q == IDLE) && rdy_q;
    assign m_valid    = mval_q;
    assign m_state    = mst_q;
    assign busy       = (state_q != IDLE);
endmodule
